// File: rtl/mc_control.sv
// mc_control: multi-cycle Moore control FSM driving the 32-bit datapath muxes,
// write enables and ALU operation select from opcode/funct.
module mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
        MEM_WB = 4'd4, MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7,
        BRANCH = 4'd8, JUMP = 4'd9, I_EXEC = 4'd10, I_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    state_t     state_q, state_d;
    logic [3:0] r_sel;
    logic       op_ok, legal;

    // 4'hf marks an unsupported funct
    assign r_sel = funct == 6'b100000 ? 4'd0 :
                   funct == 6'b100010 ? 4'd1 :
                   funct == 6'b011000 ? 4'd2 :
                   funct == 6'b011010 ? 4'd3 :
                   funct == 6'b100100 ? 4'd4 :
                   funct == 6'b100101 ? 4'd5 :
                   funct == 6'b100111 ? 4'd6 :
                   funct == 6'b000100 ? 4'd7 :
                   funct == 6'b000110 ? 4'd8 : 4'hf;
    assign op_ok = opcode == OP_R || opcode == OP_LW || opcode == OP_SW ||
                   opcode == OP_BEQ || opcode == OP_J || opcode == OP_ADDI;
    assign legal = op_ok && (opcode != OP_R || r_sel != 4'hf);
    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        alu_sel    = 4'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                illegal   = !legal;
                state_d   = !legal ? FETCH :
                            (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                            opcode == OP_R ? R_EXEC :
                            opcode == OP_BEQ ? BRANCH :
                            opcode == OP_J ? JUMP : I_EXEC;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = opcode == OP_LW ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_sel   = r_sel;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_sel    = 4'd1;
                pc_source  = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // reset silences every control output so no write can leak through
        if (rst) begin
            alu_sel    = 4'd0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_source  = 2'b00;
            pc_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end
endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the 32-bit datapath. It is the driving end of the ALU interface: it issues `alu_sel` and consumes `zero`. Per instruction it steps a Moore FSM through fetch, decode, execute, memory and write-back, and drives every datapath mux and write-enable. It sits between the instruction register (opcode/funct) and the datapath (PC, memory, register file, ALU).

## Interface
Parameters:
- none; all encodings below are fixed.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26]; stable from DECODE until the instruction ends.
- `funct` in 6: IR[5:0]; stable from DECODE until the instruction ends.
- `zero` in 1: ALU zero flag; valid only while `alu_sel`=0001 (sub).
- `alu_sel` out 4: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 nor, 0111 shl, 1000 shr.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_write` out 1: PC load enable; already qualified by `zero` for beq.
- `i_or_d`, `mem_read`, `mem_write`, `ir_write` out 1 each: memory address select (1 = ALUOut) and enables.
- `reg_write`, `reg_dst`, `mem_to_reg` out 1 each: register file write enable, dest select (1 = rd), data select (1 = MDR).
- `instr_done` out 1: high on the last cycle of each instruction.
- `illegal` out 1: high in DECODE when the opcode/funct is unsupported.
- `state` out 4: current state encoding, for debug.

## Operation
States and encodings:
- FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11.
- Unused encodings go to FETCH on the next edge.

Outputs:
- Outputs are a pure function of `state` (Moore).
- Exceptions: `alu_sel` in R_EXEC decodes from `funct`; `pc_write` in BRANCH equals `zero`.
- Unlisted outputs are 0; `alu_sel` defaults to 0000.

Per-state actions:
- FETCH: `mem_read`=1, `ir_write`=1, src_a=0, src_b=01, add, `pc_source`=00, `pc_write`=1. Next: DECODE.
- DECODE: src_a=0, src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 lw / 101011 sw → MEM_ADDR.
  - 000000 R-type → R_EXEC.
  - 000100 beq → BRANCH.
  - 000010 j → JUMP.
  - 001000 addi → I_EXEC.
  - anything else → FETCH with `illegal`=1.
- R-type funct map: 100000 add, 100010 sub, 011000 mul, 011010 div, 100100 and, 100101 or, 100111 nor, 000100 shl, 000110 shr. Any other funct: `illegal`=1 in DECODE, next FETCH.
- MEM_ADDR: src_a=1, src_b=10, add. Next: MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `i_or_d`=1, `mem_read`=1. Next: MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Next: FETCH.
- MEM_WR: `i_or_d`=1, `mem_write`=1, `instr_done`=1. Next: FETCH.
- R_EXEC: src_a=1, src_b=00, `alu_sel` from funct. Next: R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `instr_done`=1. Next: FETCH.
- BRANCH: src_a=1, src_b=00, sub, `pc_source`=01, `pc_write`=`zero`, `instr_done`=1. Next: FETCH.
- JUMP: `pc_source`=10, `pc_write`=1, `instr_done`=1. Next: FETCH.
- I_EXEC: src_a=1, src_b=10, add. Next: I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `instr_done`=1. Next: FETCH.

## Timing
- Reset: `state`=FETCH immediately. While `rst` is high, every output except `state` is forced to 0 (`alu_sel`=0000, no writes). First FETCH actions occur in the first cycle after deassertion.
- Reset mid-instruction: the instruction is abandoned with no further writes. No partial write-back after release.
- Instruction latency: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `instr_done` is high for exactly one cycle per completed instruction and never on an illegal one.
- `zero` is sampled combinationally in BRANCH only. `zero` in any other state has no effect on any output.
- Back-to-back instructions: FETCH always follows the final state with no idle cycle.

## Test plan
- Reset: hold `rst` high for 3 cycles with opcode=100011. All write enables are 0 and `state`=0. After release, FETCH outputs appear (`pc_write`=1, `alu_sel`=0000), then DECODE.
- lw (100011): state sequence 0,1,2,3,4. `mem_read`=1 in states 0 and 3. `reg_write`=1 with `mem_to_reg`=1 only in state 4. `instr_done` pulses once.
- R-type sweep: opcode=000000 with each of the 9 funct values. `alu_sel` in R_EXEC matches the map (e.g. 100111 → 0110, 000110 → 1000). `reg_dst`=1 in R_WB.
- beq (000100): with `zero`=1 in BRANCH, `pc_write`=1 and `pc_source`=01. With `zero`=0, `pc_write`=0. `alu_sel`=0001 in both cases. 3 cycles.
- Illegal: opcode=111111, then opcode=000000 with funct=111111. Each gives `illegal`=1 for one cycle, then FETCH, with no `reg_write`/`mem_write` and no `instr_done`.
- Async reset mid-instruction: assert `rst` mid-cycle in MEM_WR. `mem_write` drops before the next edge, `state`=0, and no write occurs after release.
